// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO, any depth >= 2, margins, FWFT option, flush, sticky errors
module fifo_sync_param #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1,
  parameter int FWFT       = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            wr_en,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            rd_en,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            data_valid,
  output logic                            wr_ack,
  output logic                            overflow,
  output logic                            underflow,
  output logic [1:0]                      err_sticky,
  output logic                            full,
  output logic                            empty,
  output logic                            almostfull,
  output logic                            almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic dv_q, dv_d, ack_q, ack_d, ovf_q, ovf_d, udf_q, udf_d;
  logic [1:0] err_q, err_d;
  logic wr_acc, rd_acc;
  assign full        = count_q == CW'(FIFO_DEPTH);
  assign empty       = count_q == '0;
  assign almostfull  = !full && count_q >= CW'(FIFO_DEPTH - AF_MARGIN);
  assign almostempty = !empty && count_q <= CW'(AE_MARGIN);
  // a full FIFO can still pop and an empty one can still push, so each side only checks its own limit
  assign wr_acc = !flush && wr_en && !full;
  assign rd_acc = !flush && rd_en && !empty;
  assign count      = count_q;
  assign wr_ack     = ack_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;
  assign err_sticky = err_q;
  assign data_out   = (FWFT != 0) ? (empty ? '0 : mem[rd_ptr_q]) : dout_q;
  assign data_valid = (FWFT != 0) ? !empty : dv_q;
  // next-state: explicit pointer wrap so non-power-of-2 depths work
  always_comb begin
    wr_ptr_d = flush ? '0 : !wr_acc ? wr_ptr_q : (wr_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = flush ? '0 : !rd_acc ? rd_ptr_q : (rd_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    count_d  = flush ? '0 : count_q + CW'(wr_acc) - CW'(rd_acc);
    ack_d    = wr_acc;
    ovf_d    = !flush && wr_en && full;
    udf_d    = !flush && rd_en && empty && !wr_en;
    dv_d     = rd_acc && FWFT == 0;
    dout_d   = dv_d ? mem[rd_ptr_q] : dout_q;
    err_d    = flush ? 2'b00 : err_q | {ovf_d, udf_d};
  end
  // control and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      err_q    <= err_d;
    end
  end
  // storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end
endmodule
